// File: rtl/rc4_key_search_if.sv
// Control handshake plus S RAM / ciphertext ROM / plaintext RAM ports of the
// RC4 key search engine. The slave side is the engine, the master side its host.
interface rc4_key_search_if #(
  parameter int KEY_W = 24,
  parameter int AW    = 5
);
  logic             start;
  logic             abort;
  logic [KEY_W-1:0] key_lo;
  logic [KEY_W-1:0] key_hi;
  logic             busy;
  logic             done;
  logic             found;
  logic [KEY_W-1:0] key_out;

  logic [7:0]       s_addr;
  logic [7:0]       s_data;
  logic             s_wren;
  logic [7:0]       s_q;
  logic [AW-1:0]    ct_addr;
  logic [7:0]       ct_q;
  logic [AW-1:0]    pt_addr;
  logic [7:0]       pt_data;
  logic             pt_wren;

  modport master (
    output start, abort, key_lo, key_hi, s_q, ct_q,
    input  busy, done, found, key_out,
    input  s_addr, s_data, s_wren, ct_addr, pt_addr, pt_data, pt_wren
  );

  modport slave (
    input  start, abort, key_lo, key_hi, s_q, ct_q,
    output busy, done, found, key_out,
    output s_addr, s_data, s_wren, ct_addr, pt_addr, pt_data, pt_wren
  );
endinterface

// File: rtl/rc4_key_search.sv
// Brute-force RC4 key search: per candidate key run S init, KSA and PRGA over the
// ciphertext ROM, keep plaintext while every byte is printable, stop on first full match.
module rc4_key_search #(
  parameter int         KEY_BYTES = 3,
  parameter int         MSG_LEN   = 32,
  parameter int         AW        = 5,
  parameter logic [7:0] CHAR_LO   = 8'h61,
  parameter logic [7:0] CHAR_HI   = 8'h7A
) (
  input logic              CLOCK_50,
  input logic              reset,
  rc4_key_search_if.slave  bus
);
  localparam int KEY_W = 8 * KEY_BYTES;
  localparam int KW    = AW + 1;
  localparam int KBW   = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0]  K_LAST  = KW'(MSG_LEN - 1);
  localparam logic [KBW-1:0] KB_LAST = KBW'(KEY_BYTES - 1);

  typedef enum logic [4:0] {
    S_IDLE, S_INIT,
    S_KSA_RD_I, S_KSA_WAIT_I, S_KSA_RD_J, S_KSA_WAIT_J, S_KSA_WR_I, S_KSA_WR_J,
    S_PRGA_RD_I, S_PRGA_WAIT_I, S_PRGA_RD_J, S_PRGA_WAIT_J, S_PRGA_WR_I, S_PRGA_WR_J,
    S_PRGA_RD_F, S_PRGA_WAIT_F, S_CHECK, S_NEXT_KEY, S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [7:0]       i_reg, i_next, j_reg, j_next;
  logic [7:0]       si_reg, si_next, sj_reg, sj_next, p_reg, p_next;
  logic [KBW-1:0]   kb_reg, kb_next;
  logic [KW-1:0]    k_reg, k_next;
  logic [KEY_W-1:0] key_reg, key_next, hi_reg, hi_next;
  logic             found_reg, found_next;

  logic [7:0]    s_addr_c, s_data_c, pt_data_c;
  logic          s_wren_c, pt_wren_c;
  logic [AW-1:0] ct_addr_c, pt_addr_c;

  // Key bytes MSB first; padding entries keep the selector index exactly KBW wide.
  logic [7:0] key_byte [2**KBW];
  generate
    for (genvar gi = 0; gi < 2**KBW; gi++) begin : g_key_byte
      if (gi < KEY_BYTES) begin : g_used
        assign key_byte[gi] = key_reg[KEY_W-1-8*gi -: 8];
      end else begin : g_pad
        assign key_byte[gi] = 8'h00;
      end
    end
  endgenerate

  logic accept;
  assign accept = ((p_reg >= CHAR_LO) && (p_reg <= CHAR_HI)) || (p_reg == 8'h20);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg <= S_IDLE;
      i_reg     <= '0;
      j_reg     <= '0;
      si_reg    <= '0;
      sj_reg    <= '0;
      p_reg     <= '0;
      kb_reg    <= '0;
      k_reg     <= '0;
      key_reg   <= '0;
      hi_reg    <= '0;
      found_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
      si_reg    <= si_next;
      sj_reg    <= sj_next;
      p_reg     <= p_next;
      kb_reg    <= kb_next;
      k_reg     <= k_next;
      key_reg   <= key_next;
      hi_reg    <= hi_next;
      found_reg <= found_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    si_next    = si_reg;
    sj_next    = sj_reg;
    p_next     = p_reg;
    kb_next    = kb_reg;
    k_next     = k_reg;
    key_next   = key_reg;
    hi_next    = hi_reg;
    found_next = found_reg;
    s_addr_c   = 8'h00;
    s_data_c   = 8'h00;
    s_wren_c   = 1'b0;
    ct_addr_c  = '0;
    pt_addr_c  = '0;
    pt_data_c  = 8'h00;
    pt_wren_c  = 1'b0;

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          key_next   = bus.key_lo;
          hi_next    = bus.key_hi;
          found_next = 1'b0;
          i_next     = 8'h00;
          state_next = (bus.key_lo > bus.key_hi) ? S_DONE : S_INIT;
        end
      end
      S_INIT: begin
        s_addr_c = i_reg;
        s_data_c = i_reg;
        s_wren_c = 1'b1;
        i_next   = i_reg + 8'd1;
        if (i_reg == 8'hFF) begin
          j_next     = 8'h00;
          kb_next    = '0;
          state_next = S_KSA_RD_I;
        end
      end
      S_KSA_RD_I: begin
        s_addr_c   = i_reg;
        state_next = S_KSA_WAIT_I;
      end
      S_KSA_WAIT_I: begin
        si_next    = bus.s_q;
        j_next     = j_reg + bus.s_q + key_byte[kb_reg];
        state_next = S_KSA_RD_J;
      end
      S_KSA_RD_J: begin
        s_addr_c   = j_reg;
        state_next = S_KSA_WAIT_J;
      end
      S_KSA_WAIT_J: begin
        sj_next    = bus.s_q;
        state_next = S_KSA_WR_I;
      end
      S_KSA_WR_I: begin
        s_addr_c   = i_reg;
        s_data_c   = sj_reg;
        s_wren_c   = 1'b1;
        state_next = S_KSA_WR_J;
      end
      S_KSA_WR_J: begin
        // When i == j this second write restores old s[i], which is the correct swap result.
        s_addr_c = j_reg;
        s_data_c = si_reg;
        s_wren_c = 1'b1;
        i_next   = i_reg + 8'd1;
        kb_next  = (kb_reg == KB_LAST) ? '0 : kb_reg + 1'b1;
        if (i_reg == 8'hFF) begin
          j_next     = 8'h00;
          k_next     = '0;
          state_next = S_PRGA_RD_I;
        end else begin
          state_next = S_KSA_RD_I;
        end
      end
      S_PRGA_RD_I: begin
        s_addr_c   = i_reg + 8'd1;
        i_next     = i_reg + 8'd1;
        state_next = S_PRGA_WAIT_I;
      end
      S_PRGA_WAIT_I: begin
        si_next    = bus.s_q;
        j_next     = j_reg + bus.s_q;
        state_next = S_PRGA_RD_J;
      end
      S_PRGA_RD_J: begin
        s_addr_c   = j_reg;
        state_next = S_PRGA_WAIT_J;
      end
      S_PRGA_WAIT_J: begin
        sj_next    = bus.s_q;
        state_next = S_PRGA_WR_I;
      end
      S_PRGA_WR_I: begin
        s_addr_c   = i_reg;
        s_data_c   = sj_reg;
        s_wren_c   = 1'b1;
        state_next = S_PRGA_WR_J;
      end
      S_PRGA_WR_J: begin
        s_addr_c   = j_reg;
        s_data_c   = si_reg;
        s_wren_c   = 1'b1;
        state_next = S_PRGA_RD_F;
      end
      S_PRGA_RD_F: begin
        s_addr_c   = si_reg + sj_reg;
        ct_addr_c  = k_reg[AW-1:0];
        state_next = S_PRGA_WAIT_F;
      end
      S_PRGA_WAIT_F: begin
        p_next     = bus.s_q ^ bus.ct_q;
        state_next = S_CHECK;
      end
      S_CHECK: begin
        if (accept) begin
          pt_wren_c = 1'b1;
          pt_addr_c = k_reg[AW-1:0];
          pt_data_c = p_reg;
          if (k_reg == K_LAST) begin
            found_next = 1'b1;
            state_next = S_DONE;
          end else begin
            k_next     = k_reg + 1'b1;
            state_next = S_PRGA_RD_I;
          end
        end else begin
          state_next = S_NEXT_KEY;
        end
      end
      S_NEXT_KEY: begin
        if (key_reg == hi_reg) begin
          state_next = S_DONE;
        end else begin
          key_next   = key_reg + 1'b1;
          i_next     = 8'h00;
          state_next = S_INIT;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Abort outranks start and any search step.
    if (bus.abort) begin
      state_next = S_IDLE;
      found_next = 1'b0;
    end
  end

  assign bus.busy    = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign bus.done    = (state_reg == S_DONE);
  assign bus.found   = found_reg;
  assign bus.key_out = key_reg;
  assign bus.s_addr  = s_addr_c;
  assign bus.s_data  = s_data_c;
  assign bus.s_wren  = s_wren_c;
  assign bus.ct_addr = ct_addr_c;
  assign bus.pt_addr = pt_addr_c;
  assign bus.pt_data = pt_data_c;
  assign bus.pt_wren = pt_wren_c;
endmodule

// File: tb/tb_rc4_key_search.sv
// Directed bench: a 24-bit/5-byte engine and a 32-bit/8-byte engine with behavioural
// S RAM, ciphertext ROM and plaintext RAM models around each.
module tb_rc4_key_search;
  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  rc4_key_search_if #(.KEY_W(24), .AW(3)) bus_a ();
  rc4_key_search_if #(.KEY_W(32), .AW(3)) bus_b ();

  rc4_key_search #(.KEY_BYTES(3), .MSG_LEN(5), .AW(3)) dut_a (
    .CLOCK_50(clk), .reset(reset), .bus(bus_a));
  rc4_key_search #(.KEY_BYTES(4), .MSG_LEN(8), .AW(3)) dut_b (
    .CLOCK_50(clk), .reset(reset), .bus(bus_b));

  logic [7:0] s_mem_a [256];
  logic [7:0] s_mem_b [256];
  logic [7:0] ct_mem_a [8];
  logic [7:0] ct_mem_b [8];
  logic [7:0] pt_mem_a [8];
  logic [7:0] pt_mem_b [8];
  int s_wr_a = 0;
  int pt_wr_a = 0;

  always @(posedge clk) begin
    if (bus_a.s_wren) begin
      s_mem_a[bus_a.s_addr] <= bus_a.s_data;
      s_wr_a <= s_wr_a + 1;
    end
    bus_a.s_q  <= s_mem_a[bus_a.s_addr];
    bus_a.ct_q <= ct_mem_a[bus_a.ct_addr];
    if (bus_a.pt_wren) begin
      pt_mem_a[bus_a.pt_addr] <= bus_a.pt_data;
      pt_wr_a <= pt_wr_a + 1;
    end
  end

  always @(posedge clk) begin
    if (bus_b.s_wren) s_mem_b[bus_b.s_addr] <= bus_b.s_data;
    bus_b.s_q  <= s_mem_b[bus_b.s_addr];
    bus_b.ct_q <= ct_mem_b[bus_b.ct_addr];
    if (bus_b.pt_wren) pt_mem_b[bus_b.pt_addr] <= bus_b.pt_data;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Textbook RC4 keystream byte idx for a key of nkey bytes held MSB first.
  function automatic logic [7:0] rc4_ks(input logic [31:0] key, input int nkey, input int idx);
    logic [7:0] s [256];
    logic [7:0] i, j, t, kb;
    for (int n = 0; n < 256; n++) s[n] = 8'(n);
    j = 8'h00;
    for (int n = 0; n < 256; n++) begin
      kb = key[8*(nkey-1-(n % nkey)) +: 8];
      j = j + s[n] + kb;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    i = 8'h00;
    j = 8'h00;
    for (int n = 0; n <= idx; n++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    t = s[i] + s[j];
    return s[t];
  endfunction

  task automatic start_a(input logic [23:0] lo, input logic [23:0] hi);
    @(negedge clk);
    bus_a.key_lo = lo;
    bus_a.key_hi = hi;
    bus_a.start  = 1'b1;
    @(negedge clk);
    bus_a.start  = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int budget, output int changes);
    logic [23:0] last;
    int n;
    changes = 0;
    n = 0;
    last = bus_a.key_out;
    while (!bus_a.done && n < budget) begin
      @(negedge clk);
      n++;
      if (bus_a.key_out !== last) begin
        changes++;
        last = bus_a.key_out;
      end
    end
    check({tag, "_done"}, 64'(bus_a.done), 64'(1));
  endtask

  logic [7:0] hello [5] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
  logic [7:0] msg_b [8] = '{8'h6B, 8'h65, 8'h79, 8'h20, 8'h74, 8'h65, 8'h73, 8'h74};

  initial begin
    int changes;
    int n;
    int wr_s, wr_p;

    for (int m = 0; m < 8; m++) begin
      ct_mem_a[m] = (m < 5) ? hello[m] ^ rc4_ks(32'h000249, 3, m) : 8'h00;
      ct_mem_b[m] = msg_b[m] ^ rc4_ks(32'h01020304, 4, m);
    end
    reset = 1'b1;
    bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.key_lo = '0; bus_a.key_hi = '0;
    bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.key_lo = '0; bus_b.key_hi = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_flags", 64'({bus_a.busy, bus_a.done, bus_a.found, bus_a.s_wren, bus_a.pt_wren}), 64'(0));
    check("rst_key_out", 64'(bus_a.key_out), 64'(0));
    check("rst_addr", 64'({bus_a.s_addr, bus_a.s_data, bus_a.ct_addr, bus_a.pt_addr}), 64'(0));
    $display("txn reset: busy=%0b done=%0b key_out=%06h", bus_a.busy, bus_a.done, bus_a.key_out);

    // 1: known vector, key 000249 reached after two rejected keys
    start_a(24'h000247, 24'h000249);
    check("t1_busy", 64'(bus_a.busy), 64'(1));
    check("t1_first_key", 64'(bus_a.key_out), 64'(24'h000247));
    wait_done_a("t1", 20000, changes);
    check("t1_found", 64'(bus_a.found), 64'(1));
    check("t1_key", 64'(bus_a.key_out), 64'(24'h000249));
    check("t1_keys_tried", 64'(changes), 64'(2));
    check("t1_busy_end", 64'(bus_a.busy), 64'(0));
    for (int m = 0; m < 5; m++) check($sformatf("t1_pt%0d", m), 64'(pt_mem_a[m]), 64'(hello[m]));
    $display("txn t1: done=%0b found=%0b key_out=%06h", bus_a.done, bus_a.found, bus_a.key_out);

    // 2: range miss, relaunched straight from DONE
    start_a(24'h000300, 24'h000302);
    check("t2_found_clr", 64'(bus_a.found), 64'(0));
    wait_done_a("t2", 20000, changes);
    check("t2_found", 64'(bus_a.found), 64'(0));
    check("t2_key", 64'(bus_a.key_out), 64'(24'h000302));
    check("t2_keys_tried", 64'(changes), 64'(2));
    $display("txn t2: done=%0b found=%0b key_out=%06h", bus_a.done, bus_a.found, bus_a.key_out);

    // 3: empty range ends one cycle after start with no memory traffic
    wr_s = s_wr_a; wr_p = pt_wr_a;
    start_a(24'h000005, 24'h000004);
    check("t3_done", 64'(bus_a.done), 64'(1));
    check("t3_found", 64'(bus_a.found), 64'(0));
    check("t3_busy", 64'(bus_a.busy), 64'(0));
    check("t3_key", 64'(bus_a.key_out), 64'(24'h000005));
    repeat (4) @(negedge clk);
    check("t3_no_writes", 64'((s_wr_a - wr_s) + (pt_wr_a - wr_p)), 64'(0));
    $display("txn t3: done=%0b found=%0b", bus_a.done, bus_a.found);

    // 4: abort 500 cycles into a search, then restart
    start_a(24'h000247, 24'h000249);
    repeat (499) @(negedge clk);
    bus_a.abort = 1'b1;
    @(negedge clk);
    bus_a.abort = 1'b0;
    check("t4_abort_flags", 64'({bus_a.busy, bus_a.done}), 64'(0));
    wr_s = s_wr_a; wr_p = pt_wr_a;
    repeat (20) @(negedge clk);
    check("t4_no_writes", 64'((s_wr_a - wr_s) + (pt_wr_a - wr_p)), 64'(0));
    @(negedge clk);
    bus_a.key_lo = 24'h000247; bus_a.key_hi = 24'h000249;
    bus_a.start = 1'b1; bus_a.abort = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0; bus_a.abort = 1'b0;
    check("t4_abort_beats_start", 64'(bus_a.busy), 64'(0));
    start_a(24'h000247, 24'h000249);
    wait_done_a("t4", 20000, changes);
    check("t4_found", 64'({bus_a.found, bus_a.key_out}), 64'({1'b1, 24'h000249}));
    $display("txn t4: done=%0b found=%0b key_out=%06h", bus_a.done, bus_a.found, bus_a.key_out);

    // 5: reset during a KSA write, then a normal search
    start_a(24'h000249, 24'h000249);
    n = 0;
    while (!(n >= 300 && bus_a.s_wren) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t5_ksa_wren", 64'(bus_a.s_wren), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_flags", 64'({bus_a.busy, bus_a.done, bus_a.found, bus_a.s_wren, bus_a.pt_wren}), 64'(0));
    check("t5_key", 64'(bus_a.key_out), 64'(0));
    check("t5_addr", 64'({bus_a.s_addr, bus_a.s_data, bus_a.ct_addr, bus_a.pt_addr, bus_a.pt_data}), 64'(0));
    start_a(24'h000249, 24'h000249);
    wait_done_a("t5", 20000, changes);
    check("t5_found", 64'(bus_a.found), 64'(1));
    $display("txn t5: done=%0b found=%0b key_out=%06h", bus_a.done, bus_a.found, bus_a.key_out);

    // 6: 32-bit key, 8-byte message
    @(negedge clk);
    bus_b.key_lo = 32'h01020300; bus_b.key_hi = 32'h010203FF;
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    n = 0;
    while (!bus_b.done && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("t6_done", 64'(bus_b.done), 64'(1));
    check("t6_found", 64'(bus_b.found), 64'(1));
    check("t6_key", 64'(bus_b.key_out), 64'(32'h01020304));
    for (int m = 0; m < 8; m++) check($sformatf("t6_pt%0d", m), 64'(pt_mem_b[m]), 64'(msg_b[m]));
    $display("txn t6: done=%0b found=%0b key_out=%08h", bus_b.done, bus_b.found, bus_b.key_out);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
